// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_arbiter
//  Description : Shares one sram-like memory port between the read-only
//                instruction fetch port (inst_*) and the load/store data
//                port (data_*). Data has priority; inst is forced through
//                after STARVE_LIMIT consecutive data grants while it waits.
//                Accepted requests are tracked in an in-order ID FIFO so
//                each memory response is steered to the requester that
//                issued it.
//  Ports       : clk, reset (sync, active high)
//                inst_*  fetch requester : req/addr in, addr_ok/data_ok/rdata out
//                data_*  data requester  : req/wr/wstrb/addr/wdata in,
//                                          addr_ok/data_ok/rdata out
//                mem_*   memory side     : req/wr/wstrb/addr/wdata out,
//                                          addr_ok/data_ok/rdata in
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_req_arbiter #(
   parameter int MAX_OUTST    = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   // fetch port
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // data port
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // memory port
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int c_PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int c_CNT_W = $clog2(MAX_OUTST + 1);
   localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(MAX_OUTST);
   localparam logic [c_STV_W-1:0] c_STV_ONE  = c_STV_W'(1);
   localparam logic [c_STV_W-1:0] c_STV_MAX  = c_STV_W'(STARVE_LIMIT);

   // Requester ID stored per outstanding request
   localparam logic c_ID_INST = 1'b0;
   localparam logic c_ID_DATA = 1'b1;

   logic [MAX_OUTST-1:0] r_id_fifo;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_CNT_W-1:0]   r_count;
   logic [c_STV_W-1:0]   r_starve_cnt;

   logic w_full;
   logic w_grant_data;
   logic w_grant_inst;
   logic w_push;
   logic w_pop;
   logic w_pop_id;

   // ------------------------------------------------------------------------
   // Grant: purely from registered state and current requests. A pop in the
   // same cycle does not free a slot for a grant (no bypass), which keeps the
   // path from mem_data_ok to mem_req free of combinational coupling.
   // ------------------------------------------------------------------------
   always_comb begin
      w_full       = (r_count == c_CNT_FULL);
      w_grant_data = 1'b0;
      w_grant_inst = 1'b0;
      if (!reset && !w_full) begin
         if (data_req && !(inst_req && (r_starve_cnt == c_STV_MAX)))
            w_grant_data = 1'b1;
         else if (inst_req)
            w_grant_inst = 1'b1;
      end
   end

   // Request mux towards memory; idle drives everything to zero
   always_comb begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_wstrb = 4'h0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (w_grant_data) begin
         mem_req   = 1'b1;
         mem_wr    = data_wr;
         mem_wstrb = data_wstrb;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end else if (w_grant_inst) begin
         mem_req   = 1'b1;
         mem_addr  = inst_addr;
      end
   end

   assign inst_addr_ok = w_grant_inst & mem_addr_ok;
   assign data_addr_ok = w_grant_data & mem_addr_ok;

   assign w_push   = mem_req & mem_addr_ok;
   // Responses with nothing outstanding (e.g. stragglers after reset) are dropped
   assign w_pop    = !reset && mem_data_ok && (r_count != '0);
   assign w_pop_id = r_id_fifo[r_rd_ptr];

   assign inst_data_ok = w_pop & (w_pop_id == c_ID_INST);
   assign data_data_ok = w_pop & (w_pop_id == c_ID_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   // ------------------------------------------------------------------------
   // Outstanding-ID FIFO
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_id_fifo <= '0;
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
      end else begin
         if (w_push) begin
            r_id_fifo[r_wr_ptr] <= w_grant_data ? c_ID_DATA : c_ID_INST;
            r_wr_ptr            <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Starvation counter: counts data accepts that overtook a waiting fetch
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve_cnt <= '0;
      end else if (!inst_req || inst_addr_ok) begin
         r_starve_cnt <= '0;
      end else if (data_addr_ok && (r_starve_cnt != c_STV_MAX)) begin
         r_starve_cnt <= r_starve_cnt + c_STV_ONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_req_arbiter
//  Description : Self-checking bench for sram_req_arbiter. A directed vector
//                table walks the arbitration, full, ordering and reset
//                corners; hand sequences check field muxing; a randomized
//                phase compares every output against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

   localparam int MAX_OUTST    = 4;
   localparam int STARVE_LIMIT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   sram_req_arbiter #(.MAX_OUTST(MAX_OUTST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // exp = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
   typedef struct {
      logic       rst, ireq, dreq, dwr, maok, mdok;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic i, input logic d, input logic w,
                      input logic a, input logic k, input logic [4:0] e);
      vec_t v;
      v.rst = r; v.ireq = i; v.dreq = d; v.dwr = w; v.maok = a; v.mdok = k; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic idle_inputs();
      reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
      data_wstrb = 4'h0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
   endtask

   // Reference model state
   int mq[$];          // outstanding requester IDs, 0=inst 1=data, oldest first
   int m_starve;

   initial begin
      idle_inputs();
      inst_addr = 32'h1c00_0000; data_addr = 32'h8000_0010;
      data_wdata = 32'hdead_beef; mem_rdata = 32'h0280_0c0c;

      // ---------------- directed table (sequential from reset) -------------
      add(1,1,1,0,1,1, 5'b00000);                       // reset gates everything
      add(0,1,0,0,1,0, 5'b11000);                       // lone fetch accepted
      add(0,0,0,0,0,1, 5'b00010);                       // fetch response
      add(0,1,1,0,1,1, 5'b10100);                       // conflict: D (empty pop ignored)
      add(0,1,1,0,1,1, 5'b10101);                       // D
      add(0,1,1,0,1,1, 5'b10101);                       // D -> starve=3
      add(0,1,1,0,1,1, 5'b11001);                       // forced I
      add(0,1,1,0,1,1, 5'b10110);                       // D, pop I
      add(0,1,1,0,1,1, 5'b10101);                       // D
      add(0,1,1,0,1,1, 5'b10101);                       // D
      add(0,1,1,0,1,1, 5'b11001);                       // forced I
      add(0,0,0,0,0,1, 5'b00010);                       // drain I
      for (int i = 0; i < 4; i++) add(0,0,1,0,1,0, 5'b10100); // fill to 4
      add(0,0,1,0,1,1, 5'b00001);                       // full + pop: no grant
      add(0,0,1,0,1,0, 5'b10100);                       // granted next cycle
      for (int i = 0; i < 4; i++) add(0,0,0,0,0,1, 5'b00001); // drain
      add(0,0,0,0,0,1, 5'b00000);                       // empty: response ignored
      add(0,1,0,0,1,0, 5'b11000);                       // ordering: I
      add(0,0,1,1,1,0, 5'b10100);                       // D (store)
      add(0,1,0,0,1,0, 5'b11000);                       // I
      add(0,0,0,0,0,1, 5'b00010);
      add(0,0,0,0,0,1, 5'b00001);                       // store completion
      add(0,0,0,0,0,1, 5'b00010);
      add(0,1,0,0,1,0, 5'b11000);                       // reset with 2 outstanding
      add(0,0,1,0,1,0, 5'b10100);
      add(1,0,0,0,0,0, 5'b00000);
      add(0,0,0,0,0,1, 5'b00000);                       // stale response dropped
      add(0,1,0,0,1,0, 5'b11000);
      add(0,0,0,0,0,1, 5'b00010);                       // queue restarted clean
      add(0,1,0,0,0,0, 5'b10000);                       // memory stalls request
      add(0,1,0,0,1,0, 5'b11000);
      add(0,0,0,0,0,1, 5'b00010);

      data_wstrb = 4'hf;
      foreach (tbl[i]) begin
         @(negedge clk);
         reset = tbl[i].rst; inst_req = tbl[i].ireq; data_req = tbl[i].dreq;
         data_wr = tbl[i].dwr; mem_addr_ok = tbl[i].maok; mem_data_ok = tbl[i].mdok;
         #1;
         check($sformatf("vec%0d", i),
               192'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}),
               192'(tbl[i].exp));
      end

      // ---------------- hand-written field checks ------------------------
      @(negedge clk);
      idle_inputs();
      inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
      #1;
      check("fetch_mux", 192'({mem_req, mem_wr, mem_wstrb, mem_addr, inst_addr_ok}),
            192'({1'b1, 1'b0, 4'h0, 32'h1c00_0000, 1'b1}));
      @(negedge clk);
      idle_inputs();
      mem_data_ok = 1'b1; mem_rdata = 32'h0280_0c0c;
      #1;
      check("fetch_rsp", 192'({inst_data_ok, data_data_ok, inst_rdata}),
            192'({1'b1, 1'b0, 32'h0280_0c0c}));
      @(negedge clk);
      idle_inputs();
      inst_req = 1'b1;
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3;
      data_addr = 32'h8000_1234; data_wdata = 32'h5555_aaaa; mem_addr_ok = 1'b1;
      #1;
      check("store_mux", 192'({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, data_addr_ok, inst_addr_ok}),
            192'({1'b1, 1'b1, 4'h3, 32'h8000_1234, 32'h5555_aaaa, 1'b1, 1'b0}));
      @(negedge clk);
      idle_inputs();
      mem_data_ok = 1'b1; mem_rdata = 32'h0;
      #1;
      check("store_rsp", 192'({inst_data_ok, data_data_ok}), 192'({1'b0, 1'b1}));

      // ---------------- randomized phase vs reference model --------------
      mq.delete();
      m_starve = 0;
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        full, gd, gi, pop, acc;
         logic [191:0] exp_v, act_v;
         #1;
         // Model: grant decided from the arbitration rules on queue occupancy
         full = (mq.size() == MAX_OUTST);
         gd   = !reset && !full && data_req && !(inst_req && m_starve == STARVE_LIMIT);
         gi   = !reset && !full && !gd && inst_req;
         pop  = !reset && mem_data_ok && (mq.size() > 0);
         exp_v = '0;
         exp_v[0]      = gd | gi;
         exp_v[1]      = gd ? data_wr : 1'b0;
         exp_v[5:2]    = gd ? data_wstrb : 4'h0;
         exp_v[37:6]   = gd ? data_addr : (gi ? inst_addr : 32'h0);
         exp_v[69:38]  = gd ? data_wdata : 32'h0;
         exp_v[70]     = gi && mem_addr_ok;
         exp_v[71]     = gd && mem_addr_ok;
         exp_v[72]     = pop && mq[0] == 0;
         exp_v[73]     = pop && mq[0] == 1;
         exp_v[105:74] = mem_rdata;
         exp_v[137:106]= mem_rdata;
         act_v = {54'h0, data_rdata, inst_rdata, data_data_ok, inst_data_ok,
                  data_addr_ok, inst_addr_ok, mem_wdata, mem_addr, mem_wstrb, mem_wr, mem_req};
         check($sformatf("rand%0d", cyc), act_v, exp_v);

         // Model state update for the coming edge
         acc = (gd | gi) && mem_addr_ok;
         if (reset) begin
            mq.delete();
            m_starve = 0;
         end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(gd ? 1 : 0);
            if (!inst_req || (gi && acc)) m_starve = 0;
            else if (gd && acc && m_starve < STARVE_LIMIT) m_starve++;
         end

         // Next stimulus: requesters hold until accepted
         @(negedge clk);
         if (reset || (gi && acc) || !inst_req) begin
            inst_req  = ($urandom_range(0, 3) != 0);
            inst_addr = $urandom;
         end
         if (reset || (gd && acc) || !data_req) begin
            data_req   = ($urandom_range(0, 2) != 0);
            data_wr    = $urandom_range(0, 1) == 1;
            data_wstrb = 4'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
         end
         reset       = ($urandom_range(0, 149) == 0);
         mem_addr_ok = ($urandom_range(0, 3) != 0);
         mem_data_ok = ($urandom_range(0, 1) == 1);
         mem_rdata   = $urandom;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
